// File: rtl/sram_model_pkg.sv
// rtl/sram_model_pkg.sv - shared widths, read FSM states and counter helper for sram_model
package sram_model_pkg;

    localparam int DQ_W   = 16;
    localparam int ADDR_W = 18;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE
    } state_t;

    // Increment that sticks at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/sram_model_array.sv
// rtl/sram_model_array.sv - word storage with per-byte write enables and asynchronous read port
module sram_model_array
    import sram_model_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_we_hi,
    input  logic                  i_we_lo,
    input  logic [DEPTH_LOG2-1:0] i_wr_idx,
    input  logic [DQ_W-1:0]       i_wr_data,
    input  logic [DEPTH_LOG2-1:0] i_rd_idx,
    output logic [DQ_W-1:0]       o_rd_data
);

    logic [DQ_W-1:0] r_mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (i_we_hi) r_mem[i_wr_idx][15:8] <= i_wr_data[15:8];
        if (i_we_lo) r_mem[i_wr_idx][7:0]  <= i_wr_data[7:0];
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/sram_model.sv
// rtl/sram_model.sv - SRAM bus responder with programmable read latency; SRAM_MODEL_CHECK_EN adds protocol_err
module sram_model
    import sram_model_pkg::*;
#(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DQ_W-1:0]   SRAM_DQ,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
`ifdef SRAM_MODEL_CHECK_EN
    ,
    output logic              protocol_err
`endif
);

    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic [DEPTH_LOG2-1:0] r_rd_addr;
    logic [CNT_W-1:0]      r_wr_count;
    logic [CNT_W-1:0]      r_rd_count;
    logic                  w_latch;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_wr;
    logic                  w_rd_cond;
    logic                  w_addr_chg;
    logic                  w_drive;
    logic                  w_drive_entry;
    logic [DQ_W-1:0]       w_rd_data;
    logic [63:0]           w_wr_inc;
    logic [63:0]           w_rd_inc;
    logic                  w_unused;

    assign w_idx      = SRAM_ADDR[DEPTH_LOG2-1:0];
    assign w_wr       = ~SRAM_CE_N & ~SRAM_WE_N;
    assign w_rd_cond  = ~SRAM_CE_N & SRAM_WE_N & ~SRAM_OE_N;
    assign w_addr_chg = (w_idx != r_rd_addr);
    assign w_wr_inc   = sat_inc(64'(r_wr_count), CNT_W);
    assign w_rd_inc   = sat_inc(64'(r_rd_count), CNT_W);
    assign w_unused   = ^{SRAM_ADDR[ADDR_W-1:DEPTH_LOG2], w_wr_inc[63:CNT_W], w_rd_inc[63:CNT_W]};

    // Writes win over reads and always drop any read in progress.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        if (w_wr || !w_rd_cond) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = LAT_M1;
                    w_state_nxt = (READ_LATENCY == 1) ? RD_DRIVE : RD_WAIT;
                end
                RD_WAIT: begin
                    if (w_addr_chg) begin
                        w_latch   = 1'b1;
                        w_cnt_nxt = LAT_M1;
                    end else if (r_cnt == 4'd0) begin
                        w_state_nxt = RD_DRIVE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                RD_DRIVE: begin
                    if (w_addr_chg) begin
                        w_latch = 1'b1;
                        if (READ_LATENCY != 1) begin
                            w_cnt_nxt   = LAT_M1;
                            w_state_nxt = RD_WAIT;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_drive_entry = (w_state_nxt == RD_DRIVE) && (r_state != RD_DRIVE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_rd_addr  <= '0;
            r_wr_count <= '0;
            r_rd_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch)       r_rd_addr  <= w_idx;
            if (w_wr)          r_wr_count <= w_wr_inc[CNT_W-1:0];
            if (w_drive_entry) r_rd_count <= w_rd_inc[CNT_W-1:0];
        end
    end

    sram_model_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk      (clk),
        .i_we_hi  (rst & w_wr & ~SRAM_UB_N),
        .i_we_lo  (rst & w_wr & ~SRAM_LB_N),
        .i_wr_idx (w_idx),
        .i_wr_data(SRAM_DQ),
        .i_rd_idx (r_rd_addr),
        .o_rd_data(w_rd_data)
    );

    // Bus release is combinational so the lanes float the moment the strobes drop.
    assign w_drive       = (r_state == RD_DRIVE) & w_rd_cond;
    assign rd_valid      = w_drive;
    assign SRAM_DQ[15:8] = (w_drive & ~SRAM_UB_N) ? w_rd_data[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (w_drive & ~SRAM_LB_N) ? w_rd_data[7:0]  : 8'hzz;
    assign wr_count      = r_wr_count;
    assign rd_count      = r_rd_count;

`ifdef SRAM_MODEL_CHECK_EN
    logic r_protocol_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_protocol_err <= 1'b0;
        end else if ((w_wr & ~SRAM_OE_N) | (w_wr & SRAM_UB_N & SRAM_LB_N)) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign protocol_err = r_protocol_err;
`endif

endmodule
